// File: rtl/axi4_sram_memtest.sv
// AXI4 memory self-test master: fills an SRAM window with a seed/address pattern
// in INCR write bursts, then reads it back and reports pass, error count and first bad address.
package axi4_sram_memtest_pkg;
  typedef struct packed {
    logic        aw_valid;
    logic [47:0] aw_addr;
    logic [7:0]  aw_len;
    logic [2:0]  aw_size;
    logic [1:0]  aw_burst;
    logic [3:0]  aw_id;
    logic        aw_user;
    logic        aw_lock;
    logic [3:0]  aw_cache;
    logic [2:0]  aw_prot;
    logic [3:0]  aw_qos;
    logic [3:0]  aw_region;
    logic        w_valid;
    logic [63:0] w_data;
    logic        w_last;
    logic [7:0]  w_strb;
    logic        w_user;
    logic        b_ready;
    logic        ar_valid;
    logic [47:0] ar_addr;
    logic [7:0]  ar_len;
    logic [2:0]  ar_size;
    logic [1:0]  ar_burst;
    logic [3:0]  ar_id;
    logic        ar_user;
    logic        ar_lock;
    logic [3:0]  ar_cache;
    logic [2:0]  ar_prot;
    logic [3:0]  ar_qos;
    logic [3:0]  ar_region;
    logic        r_ready;
  } axi4_master_out_type;

  typedef struct packed {
    logic        aw_ready;
    logic        w_ready;
    logic        b_valid;
    logic [1:0]  b_resp;
    logic [3:0]  b_id;
    logic        b_user;
    logic        ar_ready;
    logic        r_valid;
    logic [63:0] r_data;
    logic [1:0]  r_resp;
    logic        r_last;
    logic [3:0]  r_id;
    logic        r_user;
  } axi4_master_in_type;
endpackage

module axi4_sram_memtest
  import axi4_sram_memtest_pkg::*;
#(
  parameter logic [47:0] base_addr = 48'h0,
  parameter int          abits     = 17,
  parameter int          burst_len = 16
) (
  input  logic                clk,
  input  logic                nrst,
  input  logic                i_start,
  input  logic [31:0]         i_seed,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_pass,
  output logic [15:0]         o_err_cnt,
  output logic [47:0]         o_err_addr,
  output logic [2:0]          o_dbg_state,
  input  axi4_master_in_type  i_xmsti,
  output axi4_master_out_type o_xmsto
);
  // Handshakes: a valid stays high with a stable payload until its ready; one burst in flight.
  typedef enum logic [2:0] {IDLE, WR_AW, WR_W, WR_B, RD_AR, RD_R, DONE} state_e;

  localparam logic [47:0] WIN_END     = base_addr + (48'd1 << abits);
  localparam logic [47:0] BURST_BYTES = 48'(burst_len) << 3;
  localparam logic [8:0]  LAST_BEAT   = 9'(burst_len - 1);

  state_e      state_q, state_d;
  logic [47:0] addr_q, addr_d;
  logic [8:0]  beat_q, beat_d;
  logic [31:0] seed_q, seed_d;
  logic [15:0] err_cnt_q, err_cnt_d;
  logic [47:0] err_addr_q, err_addr_d;
  logic        pass_q, pass_d;

  logic [47:0] beat_addr, addr_next, err_at;
  logic [63:0] pattern;
  logic [1:0]  n_err;
  logic [16:0] err_sum;
  logic        to_done;
  logic        unused_in;

  assign unused_in = ^{i_xmsti.b_id, i_xmsti.b_user, i_xmsti.r_id, i_xmsti.r_user};

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      beat_q     <= '0;
      seed_q     <= '0;
      err_cnt_q  <= '0;
      err_addr_q <= '0;
      pass_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      beat_q     <= beat_d;
      seed_q     <= seed_d;
      err_cnt_q  <= err_cnt_d;
      err_addr_q <= err_addr_d;
      pass_q     <= pass_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    beat_d     = beat_q;
    seed_d     = seed_q;
    err_cnt_d  = err_cnt_q;
    err_addr_d = err_addr_q;
    pass_d     = pass_q;
    beat_addr  = addr_q + {36'd0, beat_q, 3'b000};
    addr_next  = addr_q + BURST_BYTES;
    pattern    = {seed_q ^ beat_addr[31:0], beat_addr[31:0]};
    n_err      = 2'd0;
    err_at     = beat_addr;
    err_sum    = '0;
    to_done    = 1'b0;
    case (state_q)
      IDLE: if (i_start) begin
        seed_d     = i_seed;
        addr_d     = base_addr;
        err_cnt_d  = '0;
        err_addr_d = '0;
        pass_d     = 1'b0;
        state_d    = WR_AW;
      end
      WR_AW: if (i_xmsti.aw_ready) begin
        beat_d  = '0;
        state_d = WR_W;
      end
      WR_W: if (i_xmsti.w_ready) begin
        beat_d = beat_q + 9'd1;
        if (beat_q == LAST_BEAT) state_d = WR_B;
      end
      WR_B: if (i_xmsti.b_valid) begin
        if (i_xmsti.b_resp != 2'b00) begin
          n_err  = 2'd1;
          err_at = addr_q;
        end
        if (addr_next == WIN_END) begin
          addr_d  = base_addr;
          state_d = RD_AR;
        end else begin
          addr_d  = addr_next;
          state_d = WR_AW;
        end
      end
      RD_AR: if (i_xmsti.ar_ready) begin
        beat_d  = '0;
        state_d = RD_R;
      end
      RD_R: if (i_xmsti.r_valid) begin
        if (i_xmsti.r_data != pattern || i_xmsti.r_resp != 2'b00) n_err = 2'd1;
        if (i_xmsti.r_last) begin
          // A burst cut short or overrun by the slave costs one extra error.
          if (beat_q != LAST_BEAT) n_err = n_err + 2'd1;
          addr_d  = addr_next;
          to_done = (addr_next == WIN_END);
          state_d = to_done ? DONE : RD_AR;
        end else begin
          beat_d = beat_q + 9'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (n_err != 2'd0) begin
      err_sum   = {1'b0, err_cnt_q} + {15'd0, n_err};
      err_cnt_d = err_sum[16] ? 16'hFFFF : err_sum[15:0];
      if (err_cnt_q == 16'd0) err_addr_d = err_at;
    end
    if (to_done) pass_d = (err_cnt_d == 16'd0);
  end

  always_comb begin
    o_xmsto          = '0;
    o_xmsto.aw_len   = 8'(burst_len - 1);
    o_xmsto.aw_size  = 3'd3;
    o_xmsto.aw_burst = 2'b01;
    o_xmsto.ar_len   = 8'(burst_len - 1);
    o_xmsto.ar_size  = 3'd3;
    o_xmsto.ar_burst = 2'b01;
    o_xmsto.w_strb   = 8'hFF;
    o_xmsto.aw_valid = (state_q == WR_AW);
    o_xmsto.aw_addr  = addr_q;
    o_xmsto.w_valid  = (state_q == WR_W);
    o_xmsto.w_data   = pattern;
    o_xmsto.w_last   = (beat_q == LAST_BEAT);
    o_xmsto.b_ready  = (state_q == WR_B);
    o_xmsto.ar_valid = (state_q == RD_AR);
    o_xmsto.ar_addr  = addr_q;
    o_xmsto.r_ready  = (state_q == RD_R);
  end

  assign o_busy      = (state_q != IDLE) && (state_q != DONE);
  assign o_done      = (state_q == DONE);
  assign o_pass      = pass_q;
  assign o_err_cnt   = err_cnt_q;
  assign o_err_addr  = err_addr_q;
  assign o_dbg_state = state_q;
endmodule

// File: tb/tb_axi4_sram_memtest.sv
// Bench for axi4_sram_memtest: 256-byte window, 16-beat bursts, behavioural SRAM slave
// with optional stalls, write-response error and read-data corruption.
module tb_axi4_sram_memtest;
  import axi4_sram_memtest_pkg::*;

  logic                clk;
  logic                nrst;
  logic                i_start;
  logic [31:0]         i_seed;
  logic                o_busy, o_done, o_pass;
  logic [15:0]         o_err_cnt;
  logic [47:0]         o_err_addr;
  logic [2:0]          dbg_state;
  axi4_master_in_type  xi;
  axi4_master_out_type xo;

  axi4_sram_memtest #(.base_addr(48'h0), .abits(8), .burst_len(16)) dut (
    .clk(clk), .nrst(nrst), .i_start(i_start), .i_seed(i_seed),
    .o_busy(o_busy), .o_done(o_done), .o_pass(o_pass),
    .o_err_cnt(o_err_cnt), .o_err_addr(o_err_addr), .o_dbg_state(dbg_state),
    .i_xmsti(xi), .o_xmsto(xo)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  int done_cnt = 0;
  logic [64:0] exp_q[$];
  logic [31:0] cur_seed = '0;
  bit stall_en = 0, bresp_err_first = 0, corrupt_en = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic rnd_rdy();
    return stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
  endfunction

  // SRAM slave model
  logic [63:0] mem [0:31];
  logic        s_aw_ready, s_w_ready, s_ar_ready, s_b_valid, s_r_valid, r_active, bad_b;
  logic [1:0]  s_b_resp;
  logic [47:0] w_addr, r_addr;
  logic [4:0]  w_beat, r_beat;
  logic [4:0]  r_idx;

  assign r_idx = r_addr[7:3] + r_beat;

  always_comb begin
    xi          = '0;
    xi.aw_ready = s_aw_ready;
    xi.w_ready  = s_w_ready;
    xi.b_valid  = s_b_valid;
    xi.b_resp   = s_b_resp;
    xi.ar_ready = s_ar_ready;
    xi.r_valid  = s_r_valid;
    xi.r_last   = (r_beat == 5'd15);
    xi.r_data   = mem[r_idx];
    if (corrupt_en && r_addr == 48'h80 && r_beat == 5'd3) xi.r_data = mem[r_idx] ^ 64'h1;
  end

  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      s_aw_ready <= 0; s_w_ready <= 0; s_ar_ready <= 0;
      s_b_valid <= 0; s_b_resp <= 0; s_r_valid <= 0; r_active <= 0; bad_b <= 0;
      w_addr <= 0; r_addr <= 0; w_beat <= 0; r_beat <= 0;
    end else begin
      s_aw_ready <= rnd_rdy();
      s_w_ready  <= rnd_rdy();
      s_ar_ready <= rnd_rdy();
      if (xo.aw_valid && s_aw_ready) begin
        w_addr <= xo.aw_addr;
        w_beat <= 0;
        bad_b  <= bresp_err_first && (xo.aw_addr == 48'h0);
      end
      if (xo.w_valid && s_w_ready) begin
        mem[w_addr[7:3] + w_beat] <= xo.w_data;
        w_beat <= w_beat + 5'd1;
        if (xo.w_last) begin
          s_b_valid <= 1;
          s_b_resp  <= bad_b ? 2'b10 : 2'b00;
        end
      end
      if (s_b_valid && xo.b_ready) s_b_valid <= 0;
      if (xo.ar_valid && s_ar_ready) begin
        r_active  <= 1;
        r_addr    <= xo.ar_addr;
        r_beat    <= 0;
        s_r_valid <= rnd_rdy();
      end else if (r_active) begin
        if (s_r_valid && xo.r_ready) begin
          if (r_beat == 5'd15) begin
            r_active  <= 0;
            s_r_valid <= 0;
          end else begin
            r_beat    <= r_beat + 5'd1;
            s_r_valid <= rnd_rdy();
          end
        end else if (!s_r_valid) begin
          s_r_valid <= rnd_rdy();
        end
      end
    end
  end

  // protocol monitor and scoreboard, sampled on the falling edge
  logic        p_aw_v, p_aw_r, p_w_v, p_w_r, p_ar_v, p_ar_r;
  logic [47:0] p_aw_a, p_ar_a;
  logic [64:0] p_w_pl;
  logic [64:0] exp_res;

  always @(negedge clk) begin
    if (!nrst) begin
      p_aw_v = 0; p_aw_r = 0; p_w_v = 0; p_w_r = 0; p_ar_v = 0; p_ar_r = 0;
      p_aw_a = 0; p_ar_a = 0; p_w_pl = 0;
    end else begin
      if (p_aw_v && !p_aw_r) check("aw_hold", {xo.aw_valid, xo.aw_addr}, {1'b1, p_aw_a});
      if (p_w_v && !p_w_r)   check("w_hold", {xo.w_valid, xo.w_last, xo.w_data}, {1'b1, p_w_pl});
      if (p_ar_v && !p_ar_r) check("ar_hold", {xo.ar_valid, xo.ar_addr}, {1'b1, p_ar_a});
      if (xo.w_valid && xi.w_ready) begin
        check("w_last", xo.w_last, xo.w_data[6:3] == 4'hF);
        check("w_pattern", xo.w_data[63:32], cur_seed ^ xo.w_data[31:0]);
      end
      if (xo.aw_valid || xo.w_valid || xo.b_ready) check("rw_overlap", xo.ar_valid | xo.r_ready, 1'b0);
      if (o_done) begin
        done_cnt++;
        check("busy_at_done", o_busy, 1'b0);
        if (exp_q.size() > 0) begin
          exp_res = exp_q.pop_front();
          check("result", {o_pass, o_err_cnt, o_err_addr}, exp_res);
        end else begin
          check("done_expected", o_done, 1'b0);
        end
      end
      p_aw_v = xo.aw_valid; p_aw_r = xi.aw_ready; p_aw_a = xo.aw_addr;
      p_w_v  = xo.w_valid;  p_w_r  = xi.w_ready;  p_w_pl = {xo.w_last, xo.w_data};
      p_ar_v = xo.ar_valid; p_ar_r = xi.ar_ready; p_ar_a = xo.ar_addr;
    end
  end

  // driver tasks
  task automatic run(input logic [31:0] seed, input logic exp_pass, input logic [15:0] exp_cnt,
                     input logic [47:0] exp_addr, input bit spam);
    int d0 = done_cnt;
    int cyc = 0;
    exp_q.push_back({exp_pass, exp_cnt, exp_addr});
    cur_seed = seed;
    @(negedge clk); i_seed = seed; i_start = 1;
    @(negedge clk); i_start = 0;
    check("busy_after_start", o_busy, 1'b1);
    while (done_cnt == d0 && cyc < 4000) begin
      @(negedge clk);
      if (spam) i_start = o_busy ? 1'($urandom_range(0, 1)) : 1'b0;
      cyc++;
    end
    i_start = 0;
    check("done_timeout", cyc < 4000, 1'b1);
    repeat (5) @(negedge clk);
    check("single_done", done_cnt - d0, 1);
    check("pass_held", o_pass, exp_pass);
  endtask

  initial begin
    int cyc;
    logic [47:0] a;
    nrst = 0; i_start = 0; i_seed = 0;
    repeat (3) @(negedge clk);
    check("rst_valids", {xo.aw_valid, xo.w_valid, xo.b_ready, xo.ar_valid, xo.r_ready}, 5'd0);
    check("rst_status", {o_busy, o_done, o_pass, o_err_cnt, o_err_addr}, 67'd0);
    nrst = 1;
    repeat (2) @(negedge clk);

    // clean run, zero-wait slave
    run(32'hA5A5A5A5, 1'b1, 16'd0, 48'd0, 0);
    check("mem_0x10", mem[2], 64'hA5A5A5B5_00000010);
    for (int i = 0; i < 32; i++) begin
      a = 48'(i * 8);
      check("mem_fill", mem[i], {32'hA5A5A5A5 ^ a[31:0], a[31:0]});
    end

    // corrupted read beat 3 of burst 1
    corrupt_en = 1;
    run(32'h1234_5678, 1'b0, 16'd1, 48'h98, 0);
    corrupt_en = 0;

    // error response on the first write burst
    bresp_err_first = 1;
    run(32'hDEAD_BEEF, 1'b0, 16'd1, 48'h0, 0);
    bresp_err_first = 0;

    // random ready/valid stalls
    stall_en = 1;
    run(32'h0F0F_0F0F, 1'b1, 16'd0, 48'd0, 0);
    stall_en = 0;

    // reset during write beat 5 of the first burst
    cur_seed = 32'h5555_AAAA;
    @(negedge clk); i_seed = 32'h5555_AAAA; i_start = 1;
    @(negedge clk); i_start = 0;
    cyc = 0;
    while (!(xo.w_valid && xo.w_data[31:0] == 32'h28) && cyc < 100) begin
      @(negedge clk); cyc++;
    end
    check("reach_beat5", cyc < 100, 1'b1);
    nrst = 0;
    #1;
    check("midrst_valids", {xo.aw_valid, xo.w_valid, xo.b_ready, xo.ar_valid, xo.r_ready}, 5'd0);
    check("midrst_status", {o_busy, o_done, o_pass, o_err_cnt, o_err_addr}, 67'd0);
    repeat (2) @(negedge clk);
    nrst = 1;
    @(negedge clk);
    run(32'h5555_AAAA, 1'b1, 16'd0, 48'd0, 0);

    // start spammed while busy, with a read error late in the run
    corrupt_en = 1;
    run(32'hCAFE_F00D, 1'b0, 16'd1, 48'h98, 1);
    corrupt_en = 0;

    check("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
